// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / fetch sequencer.
// Holds the state encoding and the default datapath width and reset PC.
package pc_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_STALL = 2'd2,
      S_HALT  = 2'd3
   } pc_state_t;

   localparam int          DEF_WIDTH    = 16;
   localparam logic [15:0] DEF_RESET_PC = 16'h0000;

endpackage

// File: rtl/pc_incr.sv
// Sequential-address adder: y = a + INC, wrapping modulo 2^WIDTH.
module pc_incr #(
   parameter int WIDTH = 16,
   parameter int INC   = 1
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   assign y = a + WIDTH'(INC);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, instruction-fetch handshake and IR capture for the 16-bit datapath.
// Also drives the select and both data inputs of the downstream next-PC 2:1 mux.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int               WIDTH    = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
   parameter int               INC      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stall,
   input  logic             halt,
   input  logic             br_take,
   input  logic [WIDTH-1:0] br_target,
   input  logic             imem_ready,
   input  logic [WIDTH-1:0] imem_data,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] mux_d0,
   output logic [WIDTH-1:0] mux_d1,
   output logic             mux_s,
   output logic [WIDTH-1:0] ir,
   output logic             ir_valid
);

   pc_state_t        state_reg, state_next;
   logic [WIDTH-1:0] pc_reg, pc_next;
   logic [WIDTH-1:0] ir_reg;
   logic             ir_valid_reg;
   logic             mux_s_reg;
   logic [WIDTH-1:0] mux_d1_reg;
   logic             br_fire;
   logic             fetch_done;

   pc_incr #(.WIDTH(WIDTH), .INC(INC)) u_incr (
      .a (pc_reg),
      .y (mux_d0)
   );

   // Branches are honoured only while the fetch engine is live (FETCH or STALL).
   assign br_fire    = br_take && (state_reg == S_FETCH || state_reg == S_STALL);
   // A completing fetch is squashed by a branch and ignored under stall.
   assign fetch_done = (state_reg == S_FETCH) && !stall && imem_ready && !br_fire;

   assign imem_req  = (state_reg == S_FETCH) && !stall;
   assign imem_addr = pc_reg;

   // Local equivalent of the downstream mux output, selected by this cycle's branch.
   always_comb begin
      pc_next = pc_reg;
      if (br_fire)
         pc_next = br_target;
      else if (fetch_done)
         pc_next = mux_d0;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = S_FETCH;
         S_FETCH: begin
            if (!br_fire) begin
               if (stall)
                  state_next = S_STALL;
               else if (imem_ready && halt)
                  state_next = S_HALT;
            end
         end
         S_STALL: if (!br_fire && !stall) state_next = S_FETCH;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         pc_reg       <= RESET_PC;
         ir_reg       <= '0;
         ir_valid_reg <= 1'b0;
         mux_s_reg    <= 1'b0;
         mux_d1_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         ir_valid_reg <= fetch_done;
         mux_s_reg    <= br_fire;
         if (fetch_done)
            ir_reg <= imem_data;
         if (br_fire)
            mux_d1_reg <= br_target;
      end
   end

   assign pc       = pc_reg;
   assign ir       = ir_reg;
   assign ir_valid = ir_valid_reg;
   assign mux_s    = mux_s_reg;
   assign mux_d1   = mux_d1_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand-written multi-cycle sequences.
module tb_pc_sequencer;

   typedef struct {
      logic        start, stall, halt, br;
      logic [15:0] tgt;
      logic        rdy;
      logic [15:0] data;
      logic        e_req;
      logic [15:0] e_addr, e_pc, e_ir;
      logic        e_irv, e_ms;
      logic [15:0] e_d1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stall = 1'b0, halt = 1'b0, br_take = 1'b0, imem_ready = 1'b0;
   logic [15:0] br_target = '0, imem_data = '0;
   logic        imem_req, mux_s, ir_valid;
   logic [15:0] imem_addr, pc, mux_d0, mux_d1, ir;

   int checks = 0;
   int errors = 0;
   int step_no = 0;
   vec_t tbl [21];

   pc_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .halt(halt),
      .br_take(br_take), .br_target(br_target), .imem_ready(imem_ready),
      .imem_data(imem_data), .imem_req(imem_req), .imem_addr(imem_addr),
      .pc(pc), .mux_d0(mux_d0), .mux_d1(mux_d1), .mux_s(mux_s),
      .ir(ir), .ir_valid(ir_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(logic s, logic st, logic h, logic b, logic [15:0] t,
                               logic r, logic [15:0] d, logic ereq, logic [15:0] eaddr,
                               logic [15:0] epc, logic [15:0] eir, logic eirv,
                               logic ems, logic [15:0] ed1);
      vec_t v;
      v.start = s;  v.stall = st; v.halt = h; v.br = b; v.tgt = t; v.rdy = r; v.data = d;
      v.e_req = ereq; v.e_addr = eaddr; v.e_pc = epc; v.e_ir = eir;
      v.e_irv = eirv; v.e_ms = ems; v.e_d1 = ed1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called just after a rising edge: drive, check the combinational request mid-cycle,
   // then check the registered outputs just after the next rising edge.
   task automatic apply(input vec_t v, input string tag);
      logic [15:0] exp_d0;
      start = v.start; stall = v.stall; halt = v.halt; br_take = v.br;
      br_target = v.tgt; imem_ready = v.rdy; imem_data = v.data;
      @(negedge clk);
      chk({tag, " imem_req"}, {15'd0, imem_req}, {15'd0, v.e_req});
      chk({tag, " imem_addr"}, imem_addr, v.e_addr);
      @(posedge clk);
      #1;
      exp_d0 = v.e_pc + 16'd1;
      chk({tag, " pc"}, pc, v.e_pc);
      chk({tag, " ir"}, ir, v.e_ir);
      chk({tag, " ir_valid"}, {15'd0, ir_valid}, {15'd0, v.e_irv});
      chk({tag, " mux_s"}, {15'd0, mux_s}, {15'd0, v.e_ms});
      chk({tag, " mux_d1"}, mux_d1, v.e_d1);
      chk({tag, " mux_d0"}, mux_d0, exp_d0);
      $display("%s: req=%b addr=%h -> pc=%h ir=%h ir_valid=%b mux_s=%b mux_d1=%h mux_d0=%h",
               tag, v.e_req, v.e_addr, pc, ir, ir_valid, mux_s, mux_d1, mux_d0);
      step_no++;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, " imem_req"}, {15'd0, imem_req}, 16'd0);
      chk({tag, " pc"}, pc, 16'h0000);
      chk({tag, " ir"}, ir, 16'h0000);
      chk({tag, " ir_valid"}, {15'd0, ir_valid}, 16'd0);
      chk({tag, " mux_s"}, {15'd0, mux_s}, 16'd0);
      chk({tag, " mux_d1"}, mux_d1, 16'h0000);
      chk({tag, " mux_d0"}, mux_d0, 16'h0001);
      $display("%s: pc=%h ir=%h ir_valid=%b imem_req=%b", tag, pc, ir, ir_valid, imem_req);
   endtask

   initial begin
      //          st st h  br tgt      rdy data      req addr     pc       ir       irv ms d1
      tbl[0]  = mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
      tbl[1]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'hA000, 1, 16'h0000, 16'h0001, 16'hA000, 1, 0, 16'h0000);
      tbl[2]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'hA001, 1, 16'h0001, 16'h0002, 16'hA001, 1, 0, 16'h0000);
      tbl[3]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'hA002, 1, 16'h0002, 16'h0003, 16'hA002, 1, 0, 16'h0000);
      tbl[4]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'hA003, 1, 16'h0003, 16'h0004, 16'hA003, 1, 0, 16'h0000);
      tbl[5]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 16'h0004, 16'hA003, 0, 0, 16'h0000);
      tbl[6]  = mk(0, 0, 0, 1, 16'h0040, 1, 16'hBAD1, 1, 16'h0004, 16'h0040, 16'hA003, 0, 1, 16'h0040);
      tbl[7]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'hB000, 1, 16'h0040, 16'h0041, 16'hB000, 1, 0, 16'h0040);
      tbl[8]  = mk(0, 1, 0, 0, 16'h0000, 1, 16'hBAD2, 0, 16'h0041, 16'h0041, 16'hB000, 0, 0, 16'h0040);
      tbl[9]  = mk(0, 1, 0, 0, 16'h0000, 1, 16'hBAD2, 0, 16'h0041, 16'h0041, 16'hB000, 0, 0, 16'h0040);
      tbl[10] = mk(0, 1, 0, 0, 16'h0000, 1, 16'hBAD2, 0, 16'h0041, 16'h0041, 16'hB000, 0, 0, 16'h0040);
      tbl[11] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0041, 16'h0041, 16'hB000, 0, 0, 16'h0040);
      tbl[12] = mk(0, 0, 0, 0, 16'h0000, 1, 16'hB001, 1, 16'h0041, 16'h0042, 16'hB001, 1, 0, 16'h0040);
      tbl[13] = mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0042, 16'h0042, 16'hB001, 0, 0, 16'h0040);
      tbl[14] = mk(0, 1, 0, 1, 16'h0010, 0, 16'h0000, 0, 16'h0042, 16'h0010, 16'hB001, 0, 1, 16'h0010);
      tbl[15] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0010, 16'hB001, 0, 0, 16'h0010);
      tbl[16] = mk(0, 0, 0, 0, 16'h0000, 1, 16'hC000, 1, 16'h0010, 16'h0011, 16'hC000, 1, 0, 16'h0010);
      tbl[17] = mk(0, 0, 1, 1, 16'h0005, 1, 16'hBAD3, 1, 16'h0011, 16'h0005, 16'hC000, 0, 1, 16'h0005);
      tbl[18] = mk(0, 0, 1, 0, 16'h0000, 1, 16'hC005, 1, 16'h0005, 16'h0006, 16'hC005, 1, 0, 16'h0005);
      tbl[19] = mk(1, 0, 0, 1, 16'h0077, 1, 16'hBAD4, 0, 16'h0006, 16'h0006, 16'hC005, 0, 0, 16'h0005);
      tbl[20] = mk(1, 1, 0, 0, 16'h0000, 1, 16'hBAD5, 0, 16'h0006, 16'h0006, 16'hC005, 0, 0, 16'h0005);

      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;

      for (int i = 0; i < 21; i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // Halt without a completing fetch must not leave FETCH; then PC wrap at 16'hFFFF.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000), "seqA0");
      apply(mk(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000), "seqA1");
      apply(mk(0, 0, 0, 0, 16'h0000, 1, 16'hD001, 1, 16'h0000, 16'h0001, 16'hD001, 1, 0, 16'h0000), "seqA2");
      apply(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'h0001, 16'hD001, 0, 0, 16'h0000), "seqA3");
      apply(mk(0, 0, 0, 1, 16'hFFFF, 0, 16'h0000, 1, 16'h0001, 16'hFFFF, 16'hD001, 0, 1, 16'hFFFF), "seqA4");
      apply(mk(0, 0, 0, 0, 16'h0000, 1, 16'hD002, 1, 16'hFFFF, 16'h0000, 16'hD002, 1, 0, 16'hFFFF), "seqA5");
      apply(mk(0, 0, 0, 0, 16'h0000, 1, 16'hD003, 1, 16'h0000, 16'h0001, 16'hD003, 1, 0, 16'hFFFF), "seqA6");

      // Asynchronous reset mid-FETCH with memory not ready: request must drop before the edge.
      imem_ready = 1'b0;
      #2;
      chk("seqB pre-reset imem_req", {15'd0, imem_req}, 16'd1);
      rst = 1'b1;
      #1;
      check_reset_state("seqB async reset");
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      apply(mk(0, 0, 0, 0, 16'h0000, 1, 16'hEEEE, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000), "seqB idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
